clu_pipe: RTL

Parametrised, pipelined carry-lookahead unit for the multiplier datapath. It computes the full carry vector from per-bit propagate and active-low generate inputs. The chain is split into SEG-bit segments, with one register stage per segment, so long adder rows close timing at full clock rate. A valid/ready handshake with per-stage stall lets it sit between the partial-product reduction tree and the final adder.

---
 rtl/clu_pipe.sv | 124 ++++++++++++
 1 files changed

// File: rtl/clu_pipe.sv
// rtl/clu_pipe.sv - pipelined carry-lookahead unit, one register stage per SEG-bit segment.
// Optional CLU_GMASK_EN adds the gmask port that suppresses generate per bit.
module clu_pipe #(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] p,
  input  logic [WIDTH-1:0] g_n,
  input  logic             cin,
`ifdef CLU_GMASK_EN
  input  logic [WIDTH-1:0] gmask,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   c
);

  localparam int NSEG = WIDTH / SEG;

  if (SEG < 1 || (WIDTH % SEG) != 0) begin : g_bad_cfg
    $error("clu_pipe: WIDTH must be a positive multiple of SEG");
  end

  logic [NSEG-1:0]  v_q;
  logic [NSEG-1:0]  load;
  logic [NSEG-1:0]  src_v;
  logic [WIDTH:0]   c_q    [NSEG];
  logic [WIDTH:0]   src_c  [NSEG];
  logic [WIDTH:0]   res_c  [NSEG];
  logic [WIDTH-1:0] p_q    [NSEG];
  logic [WIDTH-1:0] gn_q   [NSEG];
  logic [WIDTH-1:0] src_p  [NSEG];
  logic [WIDTH-1:0] src_gn [NSEG];
  logic [WIDTH-1:0] src_gm [NSEG];
`ifdef CLU_GMASK_EN
  logic [WIDTH-1:0] gm_q   [NSEG];
`endif

  // Walk from the output back: a stage loads when empty or when its successor takes its beat.
  always_comb begin : ready_chain
    logic down;
    load = '0;
    down = out_ready;
    for (int k = NSEG - 1; k >= 0; k--) begin
      load[k] = ~v_q[k] | down;
      down    = load[k];
    end
  end

  always_comb begin : stage_sources
    src_v     = '0;
    src_v[0]  = in_valid;
    src_c[0]  = {{WIDTH{1'b0}}, cin};
    src_p[0]  = p;
    src_gn[0] = g_n;
`ifdef CLU_GMASK_EN
    src_gm[0] = gmask;
`else
    src_gm[0] = '0;
`endif
    for (int k = 1; k < NSEG; k++) begin
      src_v[k]  = v_q[k-1];
      src_c[k]  = c_q[k-1];
      src_p[k]  = p_q[k-1];
      src_gn[k] = gn_q[k-1];
`ifdef CLU_GMASK_EN
      src_gm[k] = gm_q[k-1];
`else
      src_gm[k] = '0;
`endif
    end
  end

  // Each stage ripples its own segment, seeded by the top carry of the segment below.
  always_comb begin : segment_ripple
    logic [WIDTH:0] r;
    int             b;
    for (int k = 0; k < NSEG; k++) begin
      r = src_c[k];
      for (int j = 0; j < SEG; j++) begin
        b      = k * SEG + j;
        r[b+1] = (~src_gn[k][b] & ~src_gm[k][b]) | (src_p[k][b] & r[b]);
      end
      res_c[k] = r;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= '0;
      for (int k = 0; k < NSEG; k++) begin
        c_q[k]  <= '0;
        p_q[k]  <= '0;
        gn_q[k] <= '0;
`ifdef CLU_GMASK_EN
        gm_q[k] <= '0;
`endif
      end
    end else begin
      for (int k = 0; k < NSEG; k++) begin
        if (load[k]) begin
          v_q[k] <= src_v[k];
          if (src_v[k]) begin
            c_q[k]  <= res_c[k];
            p_q[k]  <= src_p[k];
            gn_q[k] <= src_gn[k];
`ifdef CLU_GMASK_EN
            gm_q[k] <= src_gm[k];
`endif
          end
        end
      end
    end
  end

  assign in_ready  = load[0];
  assign out_valid = v_q[NSEG-1];
  assign c         = c_q[NSEG-1];

endmodule
